snake_game_ctrl: RTL and testbench

Game sequencer for the snake design. It owns the game-state FSM (idle, run, pause, over) and generates the one-cycle `update` move strobe, whose period shortens as the snake grows. It also runs a 2-entry turn queue that debounces rapid button presses into at most one legal direction change per move. It sits between the button inputs and the snake datapath, replacing the free-running update clock and the direct button-to-direction logic.

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_game_ctrl_turn_queue.sv | 55 +++++
 rtl/snake_game_ctrl.sv | 165 ++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/game-state codes and helpers for the snake controller
package snake_pkg;

  typedef enum logic [2:0] {
    STAY  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    RIGHT = 3'd3,
    LEFT  = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int PW = 24;

  function automatic dir_t opposite(input dir_t d);
    return d == UP    ? DOWN  :
           d == DOWN  ? UP    :
           d == RIGHT ? LEFT  :
           d == LEFT  ? RIGHT : STAY;
  endfunction

  // Subtract step from a period, never going below the floor
  function automatic logic [PW-1:0] sat_sub(input logic [PW-1:0] a, input logic [PW-1:0] step,
                                            input logic [PW-1:0] floor_v);
    return (a > floor_v + step) ? a - step : floor_v;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_turn_queue.sv
// turn_queue: 2-entry direction FIFO with legality check on push, pop-before-push ordering and flush
module turn_queue
  import snake_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  logic i_push,
  input  dir_t i_push_dir,
  input  dir_t i_ref,
  input  logic i_pop,
  output dir_t o_head,
  output dir_t o_tail,
  output logic o_empty,
  output logic o_full
);

  logic [1:0] r_cnt;
  dir_t       r_q0;
  dir_t       r_q1;
  logic       w_pop;
  logic [1:0] w_cnt_post;
  logic       w_legal;
  logic       w_acc;

  // The reference is the tail (or applied dir when empty); for a pop with two entries the
  // surviving entry is the old tail, and with one entry the popped value becomes dir, so the
  // pre-pop tail is already the post-pop reference.
  assign w_pop      = i_pop && (r_cnt != 2'd0);
  assign w_cnt_post = r_cnt - {1'b0, w_pop};
  assign w_legal    = (i_push_dir != STAY) && (i_push_dir != i_ref) && (i_push_dir != opposite(i_ref));
  assign w_acc      = i_push && w_legal && (w_cnt_post != 2'd2);

  assign o_head  = r_q0;
  assign o_tail  = (r_cnt == 2'd2) ? r_q1 : r_q0;
  assign o_empty = (r_cnt == 2'd0);
  assign o_full  = (r_cnt == 2'd2);

  // Shift on pop, then write the accepted push into the first free slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_q0  <= STAY;
      r_q1  <= STAY;
    end else if (i_flush) begin
      r_cnt <= 2'd0;
    end else begin
      if (w_pop) r_q0 <= r_q1;
      if (w_acc && w_cnt_post == 2'd0) r_q0 <= i_push_dir;
      if (w_acc && w_cnt_post == 2'd1) r_q1 <= i_push_dir;
      r_cnt <= w_cnt_post + {1'b0, w_acc};
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game FSM, speed-scaled move strobe and debounced turn queue for the snake datapath
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_BASE   = 10_000_000,
  parameter int TICK_STEP   = 500_000,
  parameter int TICK_MIN    = 3_000_000,
  parameter int SPEED_EVERY = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       pause,
  input  logic       lose,
  input  logic       win,
  input  logic [6:0] size,
  output logic       update,
  output logic [2:0] dir,
  output logic       running,
  output logic [1:0] game_state
);

  localparam logic [PW-1:0] P_BASE = PW'(TICK_BASE);
  localparam logic [PW-1:0] P_STEP = PW'(TICK_STEP);
  localparam logic [PW-1:0] P_MIN  = PW'(TICK_MIN);
  localparam logic [2:0]    G_LAST = 3'(SPEED_EVERY - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_btn_q;
  logic          r_pause_q;
  logic [PW-1:0] r_div;
  logic [PW-1:0] r_period;
  logic [PW-1:0] r_period_pend;
  logic [2:0]    r_grow_cnt;
  logic [6:0]    r_size_q;
  dir_t          r_dir;
  logic          r_update;
  logic          r_running;

  logic [3:0]    w_rise;
  logic          w_press;
  dir_t          w_press_dir;
  logic          w_pause_rise;
  logic          w_end;
  logic          w_adv;
  logic          w_pop;
  logic          w_wrap;
  logic          w_grow;
  logic          w_level;
  logic          w_push;
  logic          w_flush;
  dir_t          w_ref;
  dir_t          w_q_head;
  dir_t          w_q_tail;
  logic          w_q_empty;
  logic          w_q_full;

  assign w_rise       = {up, down, right, left} & ~r_btn_q;
  assign w_press      = |w_rise;
  assign w_press_dir  = w_rise[3] ? UP : w_rise[2] ? DOWN : w_rise[1] ? RIGHT : w_rise[0] ? LEFT : STAY;
  assign w_pause_rise = pause & ~r_pause_q;
  assign w_end        = lose | win;

  // The divider only advances in cycles that stay in RUN, so a pause edge freezes the count
  // exactly where it was seen and a pop/strobe is never repeated after resume.
  assign w_adv  = (r_state == RUN) && !w_pause_rise && !w_end;
  assign w_pop  = w_adv && (r_div == r_period - PW'(2));
  assign w_wrap = w_adv && (r_div == r_period - PW'(1));

  assign w_grow  = (size != r_size_q);
  assign w_level = w_grow && (r_grow_cnt == G_LAST);

  assign w_ref   = w_q_empty ? r_dir : w_q_tail;
  assign w_flush = (w_state_nxt == OVER);
  assign w_push  = w_press && (r_state == IDLE || r_state == RUN) && (!w_q_full || w_pop);

  assign update     = r_update;
  assign dir        = r_dir;
  assign running    = r_running;
  assign game_state = r_state;

  turn_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_dir (w_press_dir),
    .i_ref      (w_ref),
    .i_pop      (w_pop),
    .o_head     (w_q_head),
    .o_tail     (w_q_tail),
    .o_empty    (w_q_empty),
    .o_full     (w_q_full)
  );

  // Game-state next-state logic; end-of-game outranks a pause edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_press ? RUN : IDLE;
      RUN:     w_state_nxt = w_end ? OVER : (w_pause_rise ? PAUSE : RUN);
      PAUSE:   w_state_nxt = w_end ? OVER : (w_pause_rise ? RUN : PAUSE);
      default: w_state_nxt = OVER;
    endcase
  end

  // State register plus registered running flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  // Previous button levels for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_q   <= 4'b0;
      r_pause_q <= 1'b0;
    end else begin
      r_btn_q   <= {up, down, right, left};
      r_pause_q <= pause;
    end
  end

  // Move divider and strobe; a shortened period is adopted only at a wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_period <= P_BASE;
      r_update <= 1'b0;
    end else begin
      r_div    <= w_wrap ? '0 : (w_adv ? r_div + PW'(1) : r_div);
      r_period <= w_wrap ? r_period_pend : r_period;
      r_update <= w_wrap;
    end
  end

  // Growth counting and speed-level period reduction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size_q      <= '0;
      r_grow_cnt    <= '0;
      r_period_pend <= P_BASE;
    end else begin
      r_size_q      <= size;
      r_grow_cnt    <= w_level ? 3'd0 : (w_grow ? r_grow_cnt + 3'd1 : r_grow_cnt);
      r_period_pend <= w_level ? sat_sub(r_period_pend, P_STEP, P_MIN) : r_period_pend;
    end
  end

  // Applied direction: loaded from the queue head one cycle before the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dir <= STAY;
    else     r_dir <= (w_pop && !w_q_empty) ? w_q_head : r_dir;
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed table and sequence checks for snake_game_ctrl with a short move period
module tb_snake_game_ctrl;
  import snake_pkg::*;

  localparam int BASE  = 100;
  localparam int STEP  = 10;
  localparam int MIN   = 30;
  localparam int EVERY = 5;

  localparam logic [3:0] MU = 4'b1000;
  localparam logic [3:0] MD = 4'b0100;
  localparam logic [3:0] MR = 4'b0010;
  localparam logic [3:0] ML = 4'b0001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic       pause = 1'b0, lose = 1'b0, win = 1'b0;
  logic [6:0] size = 7'd0;
  logic       update, running;
  logic [2:0] dir;
  logic [1:0] game_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] m1;
    logic [3:0] m2;
    dir_t       d1;
    dir_t       d2;
  } vec_t;

  vec_t tv[12];

  snake_game_ctrl #(
    .TICK_BASE   (BASE),
    .TICK_STEP   (STEP),
    .TICK_MIN    (MIN),
    .SPEED_EVERY (EVERY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .pause      (pause),
    .lose       (lose),
    .win        (win),
    .size       (size),
    .update     (update),
    .dir        (dir),
    .running    (running),
    .game_state (game_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    {up, down, right, left} = m;
    tick();
    {up, down, right, left} = 4'b0;
    tick();
  endtask

  task automatic wait_update(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!update && n < 1000);
  endtask

  task automatic count_updates(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (update) cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int c;
    tv[0]  = '{MR,      ML,      RIGHT, RIGHT};
    tv[1]  = '{MR,      MU,      RIGHT, UP};
    tv[2]  = '{MU,      MD,      UP,    UP};
    tv[3]  = '{MU,      ML,      UP,    LEFT};
    tv[4]  = '{MD,      MU,      DOWN,  DOWN};
    tv[5]  = '{ML,      MR,      LEFT,  LEFT};
    tv[6]  = '{ML,      MD,      LEFT,  DOWN};
    tv[7]  = '{MU | ML, MR,      UP,    RIGHT};
    tv[8]  = '{MD | MR, MU,      DOWN,  DOWN};
    tv[9]  = '{MR | ML, MD,      RIGHT, DOWN};
    tv[10] = '{MR,      MR,      RIGHT, RIGHT};
    tv[11] = '{MU,      MD | ML, UP,    UP};

    for (int i = 0; i < 12; i++) begin
      do_reset();
      press(tv[i].m1);
      chk($sformatf("tv%0d_state", i), game_state, RUN);
      wait_update(n);
      chk($sformatf("tv%0d_lat1", i), n, 99);
      chk($sformatf("tv%0d_dir1", i), dir, tv[i].d1);
      press(tv[i].m2);
      wait_update(n);
      chk($sformatf("tv%0d_lat2", i), n, 98);
      chk($sformatf("tv%0d_dir2", i), dir, tv[i].d2);
    end

    do_reset();
    chk("rst_state", game_state, IDLE);
    chk("rst_dir", dir, STAY);
    chk("rst_update", update, 0);
    chk("rst_running", running, 0);
    count_updates(150, c);
    chk("idle_no_update", c, 0);

    press(MR);
    chk("run_state", game_state, RUN);
    chk("run_running", running, 1);
    repeat (97) tick();
    chk("dir_before_pop", dir, STAY);
    tick();
    chk("dir_at_pop", dir, RIGHT);
    chk("update_before", update, 0);
    tick();
    chk("first_update", update, 1);
    tick();
    chk("update_one_cycle", update, 0);

    press(ML);
    press(MU);
    press(ML);
    wait_update(n);
    chk("q_lat_a", n, 93);
    chk("q_dir_up", dir, UP);
    wait_update(n);
    chk("q_lat_b", n, 100);
    chk("q_dir_left", dir, LEFT);

    press(MU);
    press(ML);
    press(MD);
    wait_update(n);
    chk("full_lat", n, 94);
    chk("full_dir1", dir, UP);
    wait_update(n);
    chk("full_dir2", dir, LEFT);
    wait_update(n);
    chk("full_dropped", dir, LEFT);

    press(MU);
    press(MR);
    repeat (94) tick();
    down = 1'b1;
    tick();
    down = 1'b0;
    wait_update(n);
    chk("popcyc_lat", n, 1);
    chk("popcyc_dir1", dir, UP);
    wait_update(n);
    chk("popcyc_dir2", dir, RIGHT);
    wait_update(n);
    chk("popcyc_dir3", dir, DOWN);

    repeat (40) tick();
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("pause_state", game_state, PAUSE);
    chk("pause_running", running, 0);
    press(ML);
    press(MR);
    count_updates(200, c);
    chk("pause_no_update", c, 0);
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("resume_state", game_state, RUN);
    wait_update(n);
    chk("resume_lat", n, 60);
    chk("pause_presses_ignored", dir, DOWN);

    for (int k = 0; k < 5; k++) begin
      size = size + 7'd1;
      tick();
    end
    wait_update(n);
    chk("speed_old_period", n, 95);
    wait_update(n);
    chk("speed_period_90", n, 90);
    for (int k = 0; k < 35; k++) begin
      size = size + 7'd1;
      tick();
    end
    wait_update(n);
    chk("speed_period_90_b", n, 55);
    wait_update(n);
    chk("speed_sat_30", n, 30);
    wait_update(n);
    chk("speed_sat_30_b", n, 30);

    repeat (5) tick();
    lose  = 1'b1;
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("over_state", game_state, OVER);
    chk("over_running", running, 0);
    press(ML);
    count_updates(300, c);
    chk("over_no_update", c, 0);
    chk("over_dir_held", dir, DOWN);
    chk("over_sticky", game_state, OVER);

    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", game_state, IDLE);
    chk("arst_dir", dir, STAY);
    chk("arst_running", running, 0);
    chk("arst_update", update, 0);
    lose = 1'b0;
    size = 7'd0;
    tick();
    rst = 1'b0;
    tick();

    press(MR);
    pause = 1'b1;
    tick();
    pause = 1'b0;
    chk("win_pre_pause", game_state, PAUSE);
    win = 1'b1;
    tick();
    chk("win_from_pause", game_state, OVER);
    win = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
